// File: rtl/sevenseg_scan_driver_if.sv
// Time fields in, multiplexed 4-digit display drive out.
// The master side is the time source, the slave side is the scan driver.
interface sevenseg_scan_driver_if;
  logic [5:0] min;
  logic [5:0] sec;
  logic       blink;
  logic       blink_sel;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (
    output min, sec, blink, blink_sel,
    input  seg, an, dp
  );

  modport slave (
    input  min, sec, blink, blink_sel,
    output seg, an, dp
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Common-anode MM.SS scan driver with a per-frame snapshot.
// It blanks the field being adjusted at a fixed blink rate.
module sevenseg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_HALF  = 25000000
) (
  input logic clk,
  input logic rst_n,
  sevenseg_scan_driver_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_HALF - 1);
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'b0111111;

  logic [CW-1:0] cnt_q, cnt_n;
  logic [1:0]    idx_q, idx_n;
  logic [5:0]    smin_q, smin_n;
  logic [5:0]    ssec_q, ssec_n;
  logic [BW-1:0] bcnt_q, bcnt_n;
  logic          off_q, off_n;
  logic [6:0]    seg_q, seg_n;
  logic [3:0]    an_q, an_n;
  logic          dp_q, dp_n;
  logic          wrap;
  logic [5:0]    field;
  logic [3:0]    digit;
  logic          hide;

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if (v >= 6'd50)      return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    logic [5:0] base;
    base = 6'd10 * {2'b00, tens_of(v)};
    return 4'(v - base);
  endfunction

  function automatic logic [6:0] pat_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  always_comb begin
    wrap   = (cnt_q == CNT_MAX);
    cnt_n  = wrap ? '0 : cnt_q + 1'b1;
    idx_n  = wrap ? idx_q + 2'd1 : idx_q;
    smin_n = smin_q;
    ssec_n = ssec_q;
    if (wrap && idx_q == 2'd3) begin
      smin_n = bus.min;
      ssec_n = bus.sec;
    end
    bcnt_n = '0;
    off_n  = 1'b0;
    if (bus.blink) begin
      bcnt_n = (bcnt_q == BLK_MAX) ? '0 : bcnt_q + 1'b1;
      off_n  = (bcnt_q == BLK_MAX) ? ~off_q : off_q;
    end
    // Outputs are built from next-state values so they line up with the count.
    field = idx_n[1] ? smin_n : ssec_n;
    digit = idx_n[0] ? tens_of(field) : ones_of(field);
    hide  = off_n && (idx_n[1] != bus.blink_sel);
    an_n  = 4'hF;
    seg_n = BLANK;
    dp_n  = 1'b1;
    if (cnt_n != '0) begin
      an_n  = ~(4'b0001 << idx_n);
      dp_n  = (idx_n != 2'd2);
      if (hide)                seg_n = BLANK;
      else if (field >= 6'd60) seg_n = DASH;
      else                     seg_n = pat_of(digit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      smin_q <= '0;
      ssec_q <= '0;
      bcnt_q <= '0;
      off_q  <= 1'b0;
      seg_q  <= BLANK;
      an_q   <= 4'hF;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_n;
      idx_q  <= idx_n;
      smin_q <= smin_n;
      ssec_q <= ssec_n;
      bcnt_q <= bcnt_n;
      off_q  <= off_n;
      seg_q  <= seg_n;
      an_q   <= an_n;
      dp_q   <= dp_n;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Randomised and directed bench for the seven-segment scan driver.
// A time-indexed reference predicts every output cycle.
module tb_sevenseg_scan_driver;

  localparam int RD = 4;
  localparam int BH = 16;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] PAT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [3:0] SCAN [16] = '{
    4'b1111, 4'b1110, 4'b1110, 4'b1110,
    4'b1111, 4'b1101, 4'b1101, 4'b1101,
    4'b1111, 4'b1011, 4'b1011, 4'b1011,
    4'b1111, 4'b0111, 4'b0111, 4'b0111
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_scan_driver_if bus();

  sevenseg_scan_driver #(
    .REFRESH_DIV(RD),
    .BLINK_HALF (BH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: t = clock edges since reset release.
  int t = 0;
  int smin = 0, ssec = 0, bage = 0;
  int m_cnt, m_idx, m_v, m_d;
  bit m_off;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; smin = 0; ssec = 0; bage = 0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      t++;
      m_cnt = t % RD;
      m_idx = (t / RD) % 4;
      if (t % (4 * RD) == 0) begin
        smin = int'(bus.min);
        ssec = int'(bus.sec);
      end
      bage  = bus.blink ? bage + 1 : 0;
      m_off = bus.blink && ((bage / BH) % 2 == 1);
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      if (m_cnt != 0) begin
        exp_an[m_idx] = 1'b0;
        exp_dp = (m_idx != 2);
        m_v = (m_idx >= 2) ? smin : ssec;
        m_d = (m_idx % 2 == 1) ? m_v / 10 : m_v % 10;
        exp_seg = (m_v >= 60) ? DASH : PAT[m_d];
        if (m_off && ((m_idx >= 2) == !bus.blink_sel)) exp_seg = 7'h7F;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.min = 6'd12; bus.sec = 6'd34;
    bus.blink = 1'b0; bus.blink_sel = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
        miscompares++;
        $display("FAIL reset an=%b seg=%b dp=%b required 1111/1111111/1",
                 bus.an, bus.seg, bus.dp);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_frame();
    int dg [4] = '{4, 3, 2, 1};
    int slot;
    logic [6:0] want;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        miscompares++;
        $display("FAIL first_frame t=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                 t, bus.an, exp_an, bus.seg, exp_seg, bus.dp, exp_dp);
      end
      if (t % 4 != 0) begin
        slot = (t / 4) % 4;
        want = (t < 16) ? PAT[0] : PAT[dg[slot]];
        vectors++;
        if (bus.seg !== want || bus.dp !== (slot != 2)) begin
          miscompares++;
          $display("FAIL digit t=%0d slot=%0d seg=%b dp=%b required %b/%b",
                   t, slot, bus.seg, bus.dp, want, slot != 2);
        end
      end
    end
  endtask

  task automatic test_scan();
    repeat (16) begin
      @(negedge clk);
      vectors++;
      if (bus.an !== SCAN[t % 16] || $countones(~bus.an) > 1) begin
        miscompares++;
        $display("FAIL scan t=%0d an=%b required %b",
                 t, bus.an, SCAN[t % 16]);
      end
    end
  endtask

  task automatic test_tearing();
    int n = 0;
    int w;
    logic [6:0] want;
    while (t % 16 != 5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (t % 16 != 5) begin
      miscompares++;
      $display("FAIL tearing_sync t=%0d required slot 1", t);
    end
    bus.sec = 6'd35;
    w = t - t % 16 + 16;
    repeat (40) begin
      @(negedge clk);
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        miscompares++;
        $display("FAIL tearing t=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                 t, bus.an, exp_an, bus.seg, exp_seg, bus.dp, exp_dp);
      end
      if (bus.an == 4'b1110 || bus.an == 4'b1101) begin
        want = (bus.an == 4'b1101) ? PAT[3] : (t < w) ? PAT[4] : PAT[5];
        vectors++;
        if (bus.seg !== want) begin
          miscompares++;
          $display("FAIL tearing_digit t=%0d an=%b seg=%b required %b",
                   t, bus.an, bus.seg, want);
        end
      end
    end
  endtask

  task automatic test_boundary(input logic [5:0] mv, input logic [5:0] sv);
    logic [6:0] want;
    int d;
    bus.min = mv; bus.sec = sv;
    repeat (40) begin
      @(negedge clk);
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        miscompares++;
        $display("FAIL boundary t=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                 t, bus.an, exp_an, bus.seg, exp_seg, bus.dp, exp_dp);
      end
    end
    repeat (16) begin
      @(negedge clk);
      if (bus.an != 4'hF) begin
        case (bus.an)
          4'b0111: d = (mv >= 60) ? -1 : int'(mv) / 10;
          4'b1011: d = (mv >= 60) ? -1 : int'(mv) % 10;
          4'b1101: d = (sv >= 60) ? -1 : int'(sv) / 10;
          default: d = (sv >= 60) ? -1 : int'(sv) % 10;
        endcase
        want = (d < 0) ? DASH : PAT[d];
        vectors++;
        if (bus.seg !== want) begin
          miscompares++;
          $display("FAIL boundary_digit min=%0d sec=%0d an=%b seg=%b required %b",
                   mv, sv, bus.an, bus.seg, want);
        end
      end
    end
  endtask

  task automatic test_blink();
    int t0, k;
    logic [6:0] want;
    bus.min = 6'd5; bus.sec = 6'd7; bus.blink_sel = 1'b1;
    repeat (32) @(negedge clk);
    bus.blink = 1'b1;
    t0 = t;
    repeat (80) begin
      @(negedge clk);
      k = t - t0;
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        miscompares++;
        $display("FAIL blink t=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                 t, bus.an, exp_an, bus.seg, exp_seg, bus.dp, exp_dp);
      end
      if (bus.an != 4'hF) begin
        case (bus.an)
          4'b0111: want = PAT[0];
          4'b1011: want = PAT[5];
          4'b1101: want = ((k / 16) % 2 == 1) ? 7'h7F : PAT[0];
          default: want = ((k / 16) % 2 == 1) ? 7'h7F : PAT[7];
        endcase
        vectors++;
        if (bus.seg !== want) begin
          miscompares++;
          $display("FAIL blink_digit k=%0d an=%b seg=%b required %b",
                   k, bus.an, bus.seg, want);
        end
      end
    end
    bus.blink = 1'b0;
    repeat (20) begin
      @(negedge clk);
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        miscompares++;
        $display("FAIL unblink t=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                 t, bus.an, exp_an, bus.seg, exp_seg, bus.dp, exp_dp);
      end
    end
  endtask

  task automatic test_sel_switch();
    int n = 0;
    bus.blink_sel = 1'b1;
    bus.blink = 1'b1;
    while (!m_off && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!m_off) begin
      miscompares++;
      $display("FAIL sel_switch_sync t=%0d phase never went off", t);
    end
    repeat (3) @(negedge clk);
    bus.blink_sel = 1'b0;
    repeat (48) begin
      @(negedge clk);
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        miscompares++;
        $display("FAIL sel_switch t=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                 t, bus.an, exp_an, bus.seg, exp_seg, bus.dp, exp_dp);
      end
    end
    bus.blink = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset an=%b seg=%b dp=%b required 1111/1111111/1",
               bus.an, bus.seg, bus.dp);
    end
    @(negedge clk);
    bus.min = 6'd47; bus.sec = 6'd58;
    rst_n = 1'b1;
    repeat (36) begin
      @(negedge clk);
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        miscompares++;
        $display("FAIL restart t=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                 t, bus.an, exp_an, bus.seg, exp_seg, bus.dp, exp_dp);
      end
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      @(negedge clk);
      vectors++;
      if (bus.an !== exp_an || bus.seg !== exp_seg || bus.dp !== exp_dp) begin
        miscompares++;
        $display("FAIL random t=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                 t, bus.an, exp_an, bus.seg, exp_seg, bus.dp, exp_dp);
      end
      if ($urandom_range(0, 9) == 0) bus.min = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) bus.sec = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 59) == 0) bus.blink = ~bus.blink;
      if ($urandom_range(0, 19) == 0) bus.blink_sel = ~bus.blink_sel;
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_scan();
    test_tearing();
    test_boundary(6'd59, 6'd0);
    test_boundary(6'd60, 6'd0);
    test_boundary(6'd0, 6'd63);
    test_blink();
    test_sel_switch();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
